axis_adder_arbiter: RTL and testbench
=====================================

// Module: axis_adder_arbiter
// PURPOSE
//  Packet-level round-robin arbiter sharing one axis_adder among C_NUM_REQ AXI-Stream requesters.
//  Each requester owns a constant; the granted requester's beats and constant are forwarded
//  to the adder's s_axis port.
//  Grants change only on tlast boundaries, so the adder constant is stable for a whole packet.
// PARAMETERS
//  C_NUM_REQ          4    number of requester streams (2..16)
//  C_AXIS_TDATA_WIDTH 512  data width, equal to the adder's
//  C_ADDER_BIT_WIDTH  32   constant width, equal to the adder's
//  C_ID_WIDTH         2    grant id width, >= clog2(C_NUM_REQ)
// PORTS
//  aclk             in   1         single clock, all logic posedge
//  aresetn          in   1         asynchronous, active-low reset
//  s_axis_tvalid    in   N         per-requester valid
//  s_axis_tready    out  N         per-requester ready; at most one bit high at any time
//  s_axis_tdata     in   N*DW      requester data, requester i at [i*DW +: DW]
//  s_axis_tkeep     in   N*DW/8    requester keep
//  s_axis_tlast     in   N         requester end-of-packet
//  ctrl_constants   in   N*CW      per-requester constant, i at [i*CW +: CW]
//  req_enable       in   N         arbitration mask; a 0 bit excludes that requester
//  m_axis_tvalid    out  1         to adder s_axis_tvalid
//  m_axis_tready    in   1         from adder s_axis_tready
//  m_axis_tdata     out  DW        to adder
//  m_axis_tkeep     out  DW/8      to adder
//  m_axis_tlast     out  1         to adder
//  m_axis_tdest     out  IDW       id of the requester owning the current output beat
//  m_ctrl_constant  out  CW        to adder ctrl_constant; registered with each beat
//  busy             out  1         1 while in XFER state
//  stat_pkt_cnt     out  N*32      per-requester completed-packet counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async assert, sync release): m_axis_tvalid=0, s_axis_tready=0, busy=0, state=IDLE.
//   Also m_axis_tdest=0, m_ctrl_constant=0, last_grant=N-1 (requester 0 wins first), counters=0.
//  FSM states: IDLE, XFER.
//   IDLE: if any (s_axis_tvalid & req_enable), the RR winner is the first set bit searched
//         from last_grant+1 upward, wrapping.
//         grant<=winner, const_r<=ctrl_constants[winner], go to XFER next cycle. Otherwise stay.
//   XFER: s_axis_tready[grant] = ~m_axis_tvalid | m_axis_tready; all other ready bits 0.
//         On accepted beat with tlast: last_grant<=grant, go to IDLE.
//  Output register: loads on (~m_axis_tvalid | m_axis_tready).
//   It captures data/keep/last, tdest=grant and m_ctrl_constant=const_r.
//   Throughput is 1 beat/clk within a packet; latency is 1 clk from s accept to m_axis_tvalid.
//  Arbitration bubble: exactly 1 idle input cycle between packets (the IDLE cycle).
//   The last output beat may still be stalled in the register during IDLE.
//  ctrl_constants and req_enable are sampled only in IDLE.
//   Changes mid-packet are ignored; deasserting enable mid-packet does not abort the packet.
//  tvalid dropping mid-packet: hold the grant and wait. There is no timeout.
//  Backpressure: m_axis_tvalid and m_axis_tdata hold stable while ~m_axis_tready (AXIS rule).
//  Single-beat packet (tlast on first beat): XFER lasts 1 accepted beat.
//  Reset mid-packet: the packet is dropped and the FSM restarts in IDLE with requester 0 first.
// CONFIGURATION
//  AXIS_ARB_STATS_EN defined: stat_pkt_cnt[i] increments on each accepted tlast beat of requester i.
//   Counters are 32 bits and wrap from 0xFFFFFFFF to 0.
//  AXIS_ARB_STATS_EN undefined: the port is still present, tied to 0, and no counter flops are built.
// STRUCTURE
//  Package axis_arb_pkg: state enum {IDLE,XFER}, clog2 function, default width constants.
//  Sub-module axis_rr_picker: combinational rotate-priority encoder.
//   Inputs: req[N], last_grant. Outputs: any, winner.
//  Top level: FSM, grant/const registers, input mux, output register, optional counters.
// TESTING
//  1. Reset, then req0 sends a 4-beat packet with constant 5 and data 0x10..0x13.
//     -> Adder input shows beats 0x10..0x13, m_ctrl_constant=5, tdest=0, tlast on beat 4.
//  2. All 4 requesters continuously valid with 2-beat packets.
//     -> Grant order 0,1,2,3,0; exactly one bubble cycle between packets.
//  3. req_enable=4'b1010, all requesters valid. -> Only requesters 1 and 3 are granted, alternating.
//  4. m_axis_tready low for 3 cycles mid-packet.
//     -> Output beat held stable, s_axis_tready[grant]=0, no beat lost or duplicated.
//  5. ctrl_constants[0] changed 7->9 mid-packet.
//     -> All beats of that packet carry 7; the next packet of requester 0 carries 9.
//  6. aresetn pulsed low during beat 2 of a packet.
//     -> m_axis_tvalid=0 immediately; after release requester 0 is granted first.
//     Stats build: counter for that requester is 0.

Source files
------------

// File: rtl/axis_adder_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_arb_pkg
// Description : Shared types and defaults for the adder round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_arb_pkg;

  // Arbiter FSM encoding
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  localparam int C_DEF_NUM_REQ          = 4;
  localparam int C_DEF_AXIS_TDATA_WIDTH = 512;
  localparam int C_DEF_ADDER_BIT_WIDTH  = 32;
  localparam int C_DEF_ID_WIDTH         = 2;

  // Ceiling log2, used to size requester ids
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_adder_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : axis_adder_arbiter_if
// Description : Requester-side and adder-side stream bundle of the arbiter.
//               slave  : arbiter view; master : requesters/adder view.
// Revision    : 1.0 - initial release
// ============================================================================
interface axis_adder_arbiter_if
  import axis_arb_pkg::*;
#(
  parameter int C_NUM_REQ          = C_DEF_NUM_REQ,
  parameter int C_AXIS_TDATA_WIDTH = C_DEF_AXIS_TDATA_WIDTH,
  parameter int C_ADDER_BIT_WIDTH  = C_DEF_ADDER_BIT_WIDTH,
  parameter int C_ID_WIDTH         = C_DEF_ID_WIDTH
);
  logic [C_NUM_REQ-1:0]                        s_axis_tvalid;
  logic [C_NUM_REQ-1:0]                        s_axis_tready;
  logic [C_NUM_REQ*C_AXIS_TDATA_WIDTH-1:0]     s_axis_tdata;
  logic [C_NUM_REQ*C_AXIS_TDATA_WIDTH/8-1:0]   s_axis_tkeep;
  logic [C_NUM_REQ-1:0]                        s_axis_tlast;
  logic [C_NUM_REQ*C_ADDER_BIT_WIDTH-1:0]      ctrl_constants;
  logic [C_NUM_REQ-1:0]                        req_enable;
  logic                                        m_axis_tvalid;
  logic                                        m_axis_tready;
  logic [C_AXIS_TDATA_WIDTH-1:0]               m_axis_tdata;
  logic [C_AXIS_TDATA_WIDTH/8-1:0]             m_axis_tkeep;
  logic                                        m_axis_tlast;
  logic [C_ID_WIDTH-1:0]                       m_axis_tdest;
  logic [C_ADDER_BIT_WIDTH-1:0]                m_ctrl_constant;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast,
    input  ctrl_constants, req_enable, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep,
    output m_axis_tlast, m_axis_tdest, m_ctrl_constant
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast,
    output ctrl_constants, req_enable, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep,
    input  m_axis_tlast, m_axis_tdest, m_ctrl_constant
  );
endinterface
`default_nettype wire

// File: rtl/axis_adder_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : axis_rr_picker
// Description : Combinational rotate-priority encoder. Searches req_i from
//               last_grant_i+1 upward with wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_rr_picker
  import axis_arb_pkg::*;
#(
  parameter int C_NUM_REQ  = C_DEF_NUM_REQ,
  parameter int C_ID_WIDTH = C_DEF_ID_WIDTH
) (
  input  wire [C_NUM_REQ-1:0]  req_i,
  input  wire [C_ID_WIDTH-1:0] last_grant_i,
  output logic                 any_o,
  output logic [C_ID_WIDTH-1:0] winner_o
);

  int idx;

  // Walk from farthest to nearest so the nearest candidate after last_grant wins
  always_comb begin
    any_o    = |req_i;
    winner_o = '0;
    idx      = 0;
    for (int k = C_NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_grant_i) + k) % C_NUM_REQ;
      if (req_i[idx]) winner_o = C_ID_WIDTH'(idx);
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_adder_arbiter
// Description : Packet-level round-robin arbiter feeding one adder stream.
//               Grants move only on tlast so the adder constant is stable for
//               a whole packet. Optional per-requester packet counters are
//               built when AXIS_ARB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_adder_arbiter
  import axis_arb_pkg::*;
#(
  parameter int C_NUM_REQ          = C_DEF_NUM_REQ,
  parameter int C_AXIS_TDATA_WIDTH = C_DEF_AXIS_TDATA_WIDTH,
  parameter int C_ADDER_BIT_WIDTH  = C_DEF_ADDER_BIT_WIDTH,
  parameter int C_ID_WIDTH         = C_DEF_ID_WIDTH
) (
  input  wire                        aclk,
  input  wire                        aresetn,
  axis_adder_arbiter_if.slave        bus,
  output logic                       busy,
  output logic [C_NUM_REQ*32-1:0]    stat_pkt_cnt
);

  localparam int C_DW  = C_AXIS_TDATA_WIDTH;
  localparam int C_KW  = C_AXIS_TDATA_WIDTH / 8;
  localparam int C_CW  = C_ADDER_BIT_WIDTH;
  localparam int C_IDW = C_ID_WIDTH;

  arb_state_e            state_q, state_d;
  logic [C_IDW-1:0]      grant_q, grant_d;
  logic [C_IDW-1:0]      last_grant_q, last_grant_d;
  logic [C_CW-1:0]       const_q, const_d;

  logic                  w_any;
  logic [C_IDW-1:0]      w_winner;
  logic [C_NUM_REQ-1:0]  w_req;
  logic [C_NUM_REQ-1:0]  w_s_ready;
  logic                  w_out_ready;
  logic                  w_accept;
  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic [C_DW-1:0]       w_sel_data;
  logic [C_KW-1:0]       w_sel_keep;
  logic [C_CW-1:0]       w_win_const;

  logic                  m_valid_q;
  logic [C_DW-1:0]       m_data_q;
  logic [C_KW-1:0]       m_keep_q;
  logic                  m_last_q;
  logic [C_IDW-1:0]      m_dest_q;
  logic [C_CW-1:0]       m_const_q;

  assign w_req = bus.s_axis_tvalid & bus.req_enable;

  axis_rr_picker #(
    .C_NUM_REQ  (C_NUM_REQ),
    .C_ID_WIDTH (C_IDW)
  ) u_picker (
    .req_i        (w_req),
    .last_grant_i (last_grant_q),
    .any_o        (w_any),
    .winner_o     (w_winner)
  );

  // Select the granted requester's beat and the winner's constant
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    w_sel_keep  = '0;
    w_win_const = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (grant_q == C_IDW'(i)) begin
        w_sel_valid = bus.s_axis_tvalid[i];
        w_sel_last  = bus.s_axis_tlast[i];
        w_sel_data  = bus.s_axis_tdata[i*C_DW +: C_DW];
        w_sel_keep  = bus.s_axis_tkeep[i*C_KW +: C_KW];
      end
      if (w_winner == C_IDW'(i)) w_win_const = bus.ctrl_constants[i*C_CW +: C_CW];
    end
  end

  // Output register can take a new beat when empty or being drained
  assign w_out_ready = ~m_valid_q | bus.m_axis_tready;
  assign w_accept    = (state_q == XFER) & w_sel_valid & w_out_ready;

  // Next-state: pick a winner in IDLE, stream its packet in XFER until tlast
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    const_d      = const_q;
    last_grant_d = last_grant_q;
    w_s_ready    = '0;
    case (state_q)
      IDLE: begin
        if (w_any) begin
          grant_d = w_winner;
          const_d = w_win_const;
          state_d = XFER;
        end
      end
      XFER: begin
        for (int i = 0; i < C_NUM_REQ; i++) begin
          w_s_ready[i] = (grant_q == C_IDW'(i)) & w_out_ready;
        end
        if (w_accept && w_sel_last) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers; requester 0 wins first after reset
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      const_q      <= '0;
      last_grant_q <= C_IDW'(C_NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      const_q      <= const_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Output beat register; contents held while the adder stalls
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      m_dest_q  <= '0;
      m_const_q <= '0;
    end else if (w_out_ready) begin
      m_valid_q <= w_accept;
      if (w_accept) begin
        m_data_q  <= w_sel_data;
        m_keep_q  <= w_sel_keep;
        m_last_q  <= w_sel_last;
        m_dest_q  <= grant_q;
        m_const_q <= const_q;
      end
    end
  end

  assign bus.s_axis_tready   = w_s_ready;
  assign bus.m_axis_tvalid   = m_valid_q;
  assign bus.m_axis_tdata    = m_data_q;
  assign bus.m_axis_tkeep    = m_keep_q;
  assign bus.m_axis_tlast    = m_last_q;
  assign bus.m_axis_tdest    = m_dest_q;
  assign bus.m_ctrl_constant = m_const_q;
  assign busy                = (state_q == XFER);

`ifdef AXIS_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < C_NUM_REQ; gi++) begin : g_stats
      logic [31:0] cnt_q;
      // Count completed packets of this requester, wrapping at 2^32
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          cnt_q <= '0;
        end else if (w_accept && w_sel_last && (grant_q == C_IDW'(gi))) begin
          cnt_q <= cnt_q + 32'd1;
        end
      end
      assign stat_pkt_cnt[gi*32 +: 32] = cnt_q;
    end
  endgenerate
`else
  assign stat_pkt_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_adder_arbiter
// Description : Directed self-checking bench for axis_adder_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_adder_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int CW  = 32;
  localparam int IDW = 2;

  logic aclk = 1'b0;
  logic aresetn = 1'b1;
  logic busy;
  logic [N*32-1:0] stat;

  always #5 aclk = ~aclk;

  axis_adder_arbiter_if #(
    .C_NUM_REQ(N), .C_AXIS_TDATA_WIDTH(DW), .C_ADDER_BIT_WIDTH(CW), .C_ID_WIDTH(IDW)
  ) bus ();

  axis_adder_arbiter #(
    .C_NUM_REQ(N), .C_AXIS_TDATA_WIDTH(DW), .C_ADDER_BIT_WIDTH(CW), .C_ID_WIDTH(IDW)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .bus          (bus),
    .busy         (busy),
    .stat_pkt_cnt (stat)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;
  int stall_from = -1;
  int stall_obs = 0;
  int stall_bad = 0;
  bit prev_stalled = 0;
  logic [DW-1:0] stall_prev;

  // requester driver state
  bit            act  [N];
  int            len  [N];
  int            beat [N];
  int            seq  [N];
  int            left [N];
  logic [DW-1:0] base [N];
  logic [CW-1:0] cst  [N];

  // observation logs
  logic [DW-1:0] o_data  [$];
  logic [3:0]    o_keep  [$];
  logic [CW-1:0] o_const [$];
  int            o_dest  [$];
  bit            o_last  [$];
  int            o_cyc   [$];
  int            in_cyc  [$];

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.s_axis_tvalid[i]            = act[i] && (left[i] > 0);
      bus.s_axis_tdata[i*DW +: DW]    = base[i] + DW'(seq[i]);
      bus.s_axis_tlast[i]             = (beat[i] == len[i] - 1);
      bus.s_axis_tkeep[i*4 +: 4]      = (beat[i] == len[i] - 1) ? 4'h7 : 4'hF;
      bus.ctrl_constants[i*CW +: CW]  = cst[i];
    end
    bus.m_axis_tready = !(stall_from >= 0 && cyc >= stall_from && cyc < stall_from + 3);
  endtask

  task automatic run_cycles(input int n);
    logic [N-1:0] acc;
    for (int k = 0; k < n; k++) begin
      @(negedge aclk);
      acc = bus.s_axis_tvalid & bus.s_axis_tready;
      for (int i = 0; i < N; i++) if (acc[i]) in_cyc.push_back(cyc);
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        o_data.push_back(bus.m_axis_tdata);
        o_keep.push_back(bus.m_axis_tkeep);
        o_const.push_back(bus.m_ctrl_constant);
        o_dest.push_back(int'(bus.m_axis_tdest));
        o_last.push_back(bus.m_axis_tlast);
        o_cyc.push_back(cyc);
      end
      if (bus.m_axis_tvalid && !bus.m_axis_tready) begin
        stall_obs++;
        if (prev_stalled && bus.m_axis_tdata !== stall_prev) stall_bad++;
        if (bus.s_axis_tready !== '0) stall_bad++;
        stall_prev   = bus.m_axis_tdata;
        prev_stalled = 1;
      end else begin
        prev_stalled = 0;
      end
      @(posedge aclk);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          seq[i]++;
          if (beat[i] == len[i] - 1) begin
            beat[i] = 0;
            left[i]--;
          end else begin
            beat[i]++;
          end
        end
      end
      drive();
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    for (int i = 0; i < N; i++) begin
      act[i] = 0; len[i] = 1; beat[i] = 0; seq[i] = 0; left[i] = 0;
      base[i] = '0; cst[i] = '0;
    end
    stall_from = -1; stall_obs = 0; stall_bad = 0; prev_stalled = 0;
    bus.req_enable = '1;
    o_data.delete(); o_keep.delete(); o_const.delete(); o_dest.delete();
    o_last.delete(); o_cyc.delete(); in_cyc.delete();
    cyc = 0;
    drive();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    cyc = 0;
    drive();
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      act[i] = 0; len[i] = 1; beat[i] = 0; seq[i] = 0; left[i] = 0;
      base[i] = '0; cst[i] = '0;
    end
    bus.req_enable = '1;
    drive();
    #3;
    aresetn = 1'b0;
    #1;
    chk_cnt++;
    if (bus.m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid got=%b exp=0", bus.m_axis_tvalid);
    else pass_cnt++;
    chk_cnt++;
    if (bus.s_axis_tready !== 4'b0000) $display("FAIL reset_tready got=%b exp=0000", bus.s_axis_tready);
    else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy);
    else pass_cnt++;
    chk_cnt++;
    if (bus.m_axis_tdest !== 2'd0 || bus.m_ctrl_constant !== 32'd0)
      $display("FAIL reset_dest_const got dest=%0d const=%h exp 0/0", bus.m_axis_tdest, bus.m_ctrl_constant);
    else pass_cnt++;
    chk_cnt++;
    if (stat !== '0) $display("FAIL reset_stats got=%h exp=0", stat);
    else pass_cnt++;
    do_reset();
    chk_cnt++;
    if (busy !== 1'b0 || bus.m_axis_tvalid !== 1'b0)
      $display("FAIL reset_idle got busy=%b tvalid=%b exp 0/0", busy, bus.m_axis_tvalid);
    else pass_cnt++;
  endtask

  task automatic test_single_packet();
    do_reset();
    act[0] = 1; len[0] = 4; left[0] = 1; base[0] = 32'h10; cst[0] = 32'd5;
    drive();
    run_cycles(12);
    chk_cnt++;
    if (o_data.size() != 4) $display("FAIL single_count got=%0d exp=4", o_data.size());
    else pass_cnt++;
    for (int b = 0; b < 4; b++) begin
      chk_cnt++;
      if (b >= o_data.size()) $display("FAIL single_beat%0d missing", b);
      else if (o_data[b] !== 32'h10 + 32'(b) || o_const[b] !== 32'd5 || o_dest[b] != 0 ||
               o_last[b] !== (b == 3) || o_keep[b] !== ((b == 3) ? 4'h7 : 4'hF))
        $display("FAIL single_beat%0d got data=%h const=%0d dest=%0d last=%b keep=%h exp data=%h const=5 dest=0 last=%b",
                 b, o_data[b], o_const[b], o_dest[b], o_last[b], o_keep[b], 32'h10 + 32'(b), (b == 3));
      else pass_cnt++;
    end
    chk_cnt++;
    if (in_cyc.size() < 1 || o_cyc.size() < 1) $display("FAIL single_latency missing beats");
    else if (o_cyc[0] != in_cyc[0] + 1)
      $display("FAIL single_latency got=%0d exp=%0d", o_cyc[0] - in_cyc[0], 1);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int r, rnd, exp_cnt;
    do_reset();
    for (int i = 0; i < N; i++) begin
      act[i] = 1; len[i] = 2; left[i] = 2; base[i] = 32'(i * 256); cst[i] = 32'(i + 1);
    end
    drive();
    run_cycles(30);
    chk_cnt++;
    if (o_data.size() != 16) $display("FAIL rr_count got=%0d exp=16", o_data.size());
    else pass_cnt++;
    for (int p = 0; p < 8; p++) begin
      r = p % 4;
      rnd = p / 4;
      for (int b = 0; b < 2; b++) begin
        chk_cnt++;
        if (2*p + b >= o_data.size()) $display("FAIL rr_pkt%0d_beat%0d missing", p, b);
        else if (o_dest[2*p+b] != r || o_data[2*p+b] !== 32'(r*256 + rnd*2 + b) ||
                 o_const[2*p+b] !== 32'(r + 1) || o_last[2*p+b] !== (b == 1))
          $display("FAIL rr_pkt%0d_beat%0d got dest=%0d data=%h const=%0d exp dest=%0d data=%h const=%0d",
                   p, b, o_dest[2*p+b], o_data[2*p+b], o_const[2*p+b], r, 32'(r*256 + rnd*2 + b), r + 1);
        else pass_cnt++;
      end
    end
    for (int p = 0; p < 7; p++) begin
      chk_cnt++;
      if (2*p + 2 >= in_cyc.size()) $display("FAIL rr_bubble%0d missing", p);
      else if (in_cyc[2*p+2] - in_cyc[2*p+1] != 2)
        $display("FAIL rr_bubble%0d got gap=%0d exp=2", p, in_cyc[2*p+2] - in_cyc[2*p+1]);
      else pass_cnt++;
    end
`ifdef AXIS_ARB_STATS_EN
    exp_cnt = 2;
`else
    exp_cnt = 0;
`endif
    for (int i = 0; i < N; i++) begin
      chk_cnt++;
      if (stat[i*32 +: 32] !== 32'(exp_cnt))
        $display("FAIL rr_stat%0d got=%0d exp=%0d", i, stat[i*32 +: 32], exp_cnt);
      else pass_cnt++;
    end
  endtask

  task automatic test_enable_mask();
    int r, rnd;
    do_reset();
    for (int i = 0; i < N; i++) begin
      act[i] = 1; len[i] = 2; left[i] = 2; base[i] = 32'(i * 256); cst[i] = 32'(i + 1);
    end
    bus.req_enable = 4'b1010;
    drive();
    run_cycles(20);
    chk_cnt++;
    if (o_data.size() != 8) $display("FAIL mask_count got=%0d exp=8", o_data.size());
    else pass_cnt++;
    for (int p = 0; p < 4; p++) begin
      r = (p % 2 == 0) ? 1 : 3;
      rnd = p / 2;
      chk_cnt++;
      if (2*p + 1 >= o_data.size()) $display("FAIL mask_pkt%0d missing", p);
      else if (o_dest[2*p] != r || o_dest[2*p+1] != r || o_data[2*p] !== 32'(r*256 + rnd*2) ||
               o_data[2*p+1] !== 32'(r*256 + rnd*2 + 1))
        $display("FAIL mask_pkt%0d got dest=%0d data=%h exp dest=%0d data=%h",
                 p, o_dest[2*p], o_data[2*p], r, 32'(r*256 + rnd*2));
      else pass_cnt++;
    end
    chk_cnt++;
    if (busy !== 1'b0 || bus.s_axis_tready !== 4'b0000)
      $display("FAIL mask_idle got busy=%b tready=%b exp 0/0000", busy, bus.s_axis_tready);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    act[0] = 1; len[0] = 6; left[0] = 1; base[0] = 32'h40; cst[0] = 32'd3;
    stall_from = 4;
    drive();
    run_cycles(16);
    chk_cnt++;
    if (stall_obs != 3) $display("FAIL bp_stall_cycles got=%0d exp=3", stall_obs);
    else pass_cnt++;
    chk_cnt++;
    if (stall_bad != 0) $display("FAIL bp_stable got=%0d violations exp=0", stall_bad);
    else pass_cnt++;
    chk_cnt++;
    if (o_data.size() != 6) $display("FAIL bp_count got=%0d exp=6", o_data.size());
    else pass_cnt++;
    for (int b = 0; b < 6; b++) begin
      chk_cnt++;
      if (b >= o_data.size()) $display("FAIL bp_beat%0d missing", b);
      else if (o_data[b] !== 32'h40 + 32'(b) || o_last[b] !== (b == 5))
        $display("FAIL bp_beat%0d got data=%h last=%b exp data=%h last=%b",
                 b, o_data[b], o_last[b], 32'h40 + 32'(b), (b == 5));
      else pass_cnt++;
    end
  endtask

  task automatic test_const_sampling();
    do_reset();
    act[0] = 1; len[0] = 4; left[0] = 2; base[0] = 32'h70; cst[0] = 32'd7;
    drive();
    run_cycles(3);
    cst[0] = 32'd9;
    drive();
    run_cycles(20);
    chk_cnt++;
    if (o_data.size() != 8) $display("FAIL const_count got=%0d exp=8", o_data.size());
    else pass_cnt++;
    for (int b = 0; b < 8; b++) begin
      chk_cnt++;
      if (b >= o_data.size()) $display("FAIL const_beat%0d missing", b);
      else if (o_const[b] !== ((b < 4) ? 32'd7 : 32'd9) || o_data[b] !== 32'h70 + 32'(b))
        $display("FAIL const_beat%0d got const=%0d data=%h exp const=%0d data=%h",
                 b, o_const[b], o_data[b], (b < 4) ? 7 : 9, 32'h70 + 32'(b));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    act[0] = 1; len[0] = 1; left[0] = 1; base[0] = 32'hA0; cst[0] = 32'd1;
    act[1] = 1; len[1] = 4; left[1] = 1; base[1] = 32'hB0; cst[1] = 32'd2;
    drive();
    run_cycles(4);
    chk_cnt++;
    if (busy !== 1'b1 || bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdest !== 2'd1)
      $display("FAIL rstmid_pre got busy=%b tvalid=%b dest=%0d exp 1/1/1", busy, bus.m_axis_tvalid, bus.m_axis_tdest);
    else pass_cnt++;
    aresetn = 1'b0;
    #1;
    chk_cnt++;
    if (bus.m_axis_tvalid !== 1'b0 || busy !== 1'b0 || bus.s_axis_tready !== 4'b0000)
      $display("FAIL rstmid_async got tvalid=%b busy=%b tready=%b exp 0/0/0000",
               bus.m_axis_tvalid, busy, bus.s_axis_tready);
    else pass_cnt++;
    do_reset();
    chk_cnt++;
    if (stat !== '0) $display("FAIL rstmid_stats got=%h exp=0", stat);
    else pass_cnt++;
    act[0] = 1; len[0] = 1; left[0] = 1; base[0] = 32'hC0; cst[0] = 32'd3;
    act[1] = 1; len[1] = 4; left[1] = 1; base[1] = 32'hB0; cst[1] = 32'd2;
    drive();
    run_cycles(14);
    chk_cnt++;
    if (o_data.size() != 5) $display("FAIL rstmid_count got=%0d exp=5", o_data.size());
    else pass_cnt++;
    chk_cnt++;
    if (o_data.size() < 1) $display("FAIL rstmid_first missing");
    else if (o_dest[0] != 0 || o_data[0] !== 32'hC0 || o_const[0] !== 32'd3 || o_last[0] !== 1'b1)
      $display("FAIL rstmid_first got dest=%0d data=%h const=%0d exp dest=0 data=c0 const=3",
               o_dest[0], o_data[0], o_const[0]);
    else pass_cnt++;
    for (int b = 0; b < 4; b++) begin
      chk_cnt++;
      if (b + 1 >= o_data.size()) $display("FAIL rstmid_req1_beat%0d missing", b);
      else if (o_dest[b+1] != 1 || o_data[b+1] !== 32'hB0 + 32'(b) || o_const[b+1] !== 32'd2)
        $display("FAIL rstmid_req1_beat%0d got dest=%0d data=%h const=%0d exp dest=1 data=%h const=2",
                 b, o_dest[b+1], o_data[b+1], o_const[b+1], 32'hB0 + 32'(b));
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_enable_mask();
    test_backpressure();
    test_const_sampling();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
